// File: rtl/waveword_seq_if.sv
// waveword_seq_if: host control, wave RAM port and player handshake for waveword_seq.
interface waveword_seq_if #(
    parameter int ADDR_W = 10,
    parameter int LOOP_W = 8
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [LOOP_W-1:0] loop_cnt;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic [31:0]       wave_word;
    logic              req;
    logic              ww_done;
    logic              busy;
    logic              seq_done;
    logic              addr_err;
    logic [15:0]       word_cnt;

    modport master (
        output start, abort, base_addr, loop_cnt, rd_data, ww_done,
        input  rd_en, rd_addr, wave_word, req, busy, seq_done, addr_err, word_cnt
    );

    modport slave (
        input  start, abort, base_addr, loop_cnt, rd_data, ww_done,
        output rd_en, rd_addr, wave_word, req, busy, seq_done, addr_err, word_cnt
    );
endinterface

// File: rtl/waveword_seq.sv
// waveword_seq: walks a wave-word list in RAM and hands each word to the DA player.
// Optional WAVEWORD_SEQ_PREFETCH_EN: fetch the next word while the player runs so
// the following req comes one cycle after ww_done instead of three.
module waveword_seq #(
    parameter int ADDR_W = 10,
    parameter int LOOP_W = 8
) (
    input logic           clk,
    input logic           rstn,
    waveword_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT_RD, ISSUE, RUN, DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d, next_addr;
    logic [LOOP_W-1:0] loops_q, loops_d;
    logic [31:0]       wave_word_q, wave_word_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic              addr_err_q, addr_err_d;
    logic              term, last, run_done, pf_rd, pf_hit;

    assign term      = wave_word_q[7:0] == 8'd0;
    assign last      = addr_q == '1;
    assign run_done  = state_q == RUN && bus.ww_done && !bus.abort;
    assign next_addr = term ? base_q : addr_q + ADDR_W'(1);

`ifdef WAVEWORD_SEQ_PREFETCH_EN
    logic [31:0] pf_buf_q;
    logic        pf_valid_q, pf_pend_q;

    assign pf_rd  = state_q == RUN && !pf_valid_q && !pf_pend_q && !(term && loops_q == '0)
                    && !last && !bus.ww_done && !bus.abort;
    assign pf_hit = pf_valid_q;

    // prefetch buffer: at most one read in flight, dropped whenever RUN is left
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pf_buf_q   <= '0;
            pf_valid_q <= 1'b0;
            pf_pend_q  <= 1'b0;
        end else begin
            pf_pend_q  <= pf_rd;
            pf_valid_q <= state_q == RUN && !bus.abort && !bus.ww_done && (pf_valid_q || pf_pend_q);
            if (pf_pend_q) pf_buf_q <= bus.rd_data;
        end
    end
`else
    assign pf_rd  = 1'b0;
    assign pf_hit = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next state; abort returns to IDLE from anywhere and also beats a same-cycle start
    always_comb begin
        state_d = state_q;
        if (bus.abort) state_d = IDLE;
        else case (state_q)
            IDLE:    state_d = bus.start ? FETCH : IDLE;
            FETCH:   state_d = WAIT_RD;
            WAIT_RD: state_d = ISSUE;
            ISSUE:   state_d = RUN;
            RUN:     if (bus.ww_done) state_d = pf_hit ? ISSUE :
                                                term   ? (loops_q != '0 ? FETCH : DONE) :
                                                         (last ? IDLE : FETCH);
            default: state_d = IDLE;
        endcase
    end

    // outputs decoded from state; a prefetch read borrows the RAM port during RUN
    always_comb begin
        bus.rd_en     = state_q == FETCH || pf_rd;
        bus.rd_addr   = pf_rd ? next_addr : addr_q;
        bus.req       = state_q == ISSUE;
        bus.busy      = state_q != IDLE;
        bus.seq_done  = state_q == DONE;
        bus.wave_word = wave_word_q;
        bus.addr_err  = addr_err_q;
        bus.word_cnt  = word_cnt_q;
    end

    // datapath next values: list address, replay count, current word, counters
    always_comb begin
        addr_d      = addr_q;
        base_d      = base_q;
        loops_d     = loops_q;
        wave_word_d = wave_word_q;
        word_cnt_d  = word_cnt_q;
        addr_err_d  = addr_err_q;
        if (state_q == IDLE && bus.start && !bus.abort) begin
            addr_d     = bus.base_addr;
            base_d     = bus.base_addr;
            loops_d    = bus.loop_cnt;
            word_cnt_d = '0;
            addr_err_d = 1'b0;
        end
        if (state_q == WAIT_RD && !bus.abort) wave_word_d = bus.rd_data;
        if (state_q == ISSUE && word_cnt_q != '1) word_cnt_d = word_cnt_q + 16'd1;
        if (run_done) begin
            if (term ? loops_q != '0 : !last) begin
                addr_d  = next_addr;
                loops_d = term ? loops_q - LOOP_W'(1) : loops_q;
            end
            addr_err_d = addr_err_q | (!term & last);
`ifdef WAVEWORD_SEQ_PREFETCH_EN
            if (pf_hit) wave_word_d = pf_buf_q;
`endif
        end
    end

    // datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q      <= '0;
            base_q      <= '0;
            loops_q     <= '0;
            wave_word_q <= '0;
            word_cnt_q  <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            base_q      <= base_d;
            loops_q     <= loops_d;
            wave_word_q <= wave_word_d;
            word_cnt_q  <= word_cnt_d;
            addr_err_q  <= addr_err_d;
        end
    end
endmodule

// File: tb/tb_waveword_seq.sv
// tb_waveword_seq: scoreboard bench for waveword_seq with RAM and player models.
module tb_waveword_seq;
`ifdef WAVEWORD_SEQ_PREFETCH_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    waveword_seq_if #(.ADDR_W(10), .LOOP_W(8)) bus ();
    waveword_seq #(.ADDR_W(10), .LOOP_W(8)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    logic [31:0] ram [0:1023];
    logic [31:0] sb [$];
    int n_chk = 0, n_pass = 0, cyc = 0;
    int n_req, n_sd, n_base, pend, ab_cnt, abort_at = -1, start_cyc, done_cyc, abort_cyc;
    int exp_n, exp_sd, exp_err;
    int dly = 5;
    logic prev_req = 1'b0;
    logic [9:0] cur_base;

    // synchronous wave RAM: data one cycle after rd_en
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.ww_done = 1'b0;
        if (ab_cnt > 0) begin
            ab_cnt--;
            if (ab_cnt == 0) begin
                bus.abort = 1'b1;
                abort_cyc = cyc;
            end
        end
        if (bus.req) begin
            chk("req_gap", prev_req, 0);
            if (sb.size() == 0) chk("extra_req", bus.req, 0);
            else chk("word", bus.wave_word, sb.pop_front());
            if (done_cyc < 0) chk("lat_start", cyc - start_cyc, 3);
            else chk("lat_next", cyc - done_cyc, LAT);
            n_req++;
            pend = dly;
            if (n_req == abort_at) ab_cnt = 2;
        end
        prev_req = bus.req;
        if (bus.seq_done) n_sd++;
        if (bus.rd_en && bus.rd_addr == cur_base) n_base++;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                bus.ww_done = 1'b1;
                done_cyc = cyc;
            end
        end
    endtask

    task automatic begin_seq(input logic [9:0] base, input logic [7:0] loops);
        logic [9:0] a;
        logic [31:0] w;
        int l;
        a = base;
        l = loops;
        sb.delete();
        exp_n = 0; exp_sd = 0; exp_err = 0;
        n_req = 0; n_sd = 0; n_base = 0;
        cur_base = base;
        while (exp_n < 4096) begin
            w = ram[a];
            sb.push_back(w);
            exp_n++;
            if (w[7:0] == 8'd0) begin
                if (l == 0) begin
                    exp_sd = 1;
                    break;
                end
                l--;
                a = base;
            end else if (a == 10'h3FF) begin
                exp_err = 1;
                break;
            end else a++;
        end
        bus.base_addr = base;
        bus.loop_cnt = loops;
        bus.start = 1'b1;
        start_cyc = cyc;
        done_cyc = -1;
        tick();
    endtask

    task automatic finish_seq(input string name);
        int t;
        t = 0;
        while (bus.busy && t < 2000) begin
            tick();
            t++;
        end
        chk({name, "_timeout"}, bus.busy, 0);
        chk({name, "_nreq"}, n_req, exp_n);
        chk({name, "_word_cnt"}, bus.word_cnt, exp_n);
        chk({name, "_seq_done"}, n_sd, exp_sd);
        chk({name, "_addr_err"}, bus.addr_err, exp_err);
        chk({name, "_sb_left"}, sb.size(), 0);
    endtask

    initial begin
        int t;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        ram[10'h010] = 32'h4000_0105;
        ram[10'h011] = 32'h0000_0000;
        ram[10'h100] = 32'h1234_5603;
        ram[10'h101] = 32'hABCD_EF11;
        ram[10'h102] = 32'h7F00_2200;
        ram[10'h3FE] = 32'h1234_5601;
        ram[10'h3FF] = 32'h0000_0A07;
        bus.start = 1'b0; bus.abort = 1'b0; bus.ww_done = 1'b0;
        bus.base_addr = '0; bus.loop_cnt = '0;
        pend = 0; ab_cnt = 0; cur_base = '0;
        repeat (3) tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_req", bus.req, 0);
        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_wave_word", bus.wave_word, 0);
        chk("rst_word_cnt", bus.word_cnt, 0);
        chk("rst_flags", {bus.seq_done, bus.addr_err}, 0);
        rstn = 1'b1;
        tick();

        begin_seq(10'h010, 8'd0);
        finish_seq("single");

        begin_seq(10'h100, 8'd2);
        finish_seq("loop");
        chk("loop_base_reads", n_base, 3);

        abort_at = 2;
        begin_seq(10'h100, 8'd0);
        t = 0;
        while (bus.busy && t < 200) begin
            tick();
            t++;
        end
        chk("abort_busy_lat", cyc - abort_cyc, 1);
        repeat (12) tick();
        chk("abort_nreq", n_req, 2);
        chk("abort_seq_done", n_sd, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_word_cnt", bus.word_cnt, 2);
        abort_at = -1;
        sb.delete();

        begin_seq(10'h3FE, 8'd0);
        finish_seq("addr_end");
        begin_seq(10'h010, 8'd0);
        chk("err_clear", bus.addr_err, 0);
        finish_seq("after_err");

        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        chk("start_abort_busy", bus.busy, 0);
        chk("start_abort_rd_en", bus.rd_en, 0);
        tick();
        chk("start_abort_rd_en2", bus.rd_en, 0);

        begin_seq(10'h010, 8'd0);
        tick();
        bus.base_addr = 10'h100;
        bus.loop_cnt = 8'd3;
        bus.start = 1'b1;
        tick();
        finish_seq("start_busy");

        begin_seq(10'h100, 8'd1);
        t = 0;
        while (n_req < 2 && t < 200) begin
            tick();
            t++;
        end
        chk("mid_rst_reached", n_req, 2);
        rstn = 1'b0;
        #2;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_word_cnt", bus.word_cnt, 0);
        chk("mid_rst_wave_word", bus.wave_word, 0);
        pend = 0;
        tick();
        tick();
        chk("mid_rst_req", bus.req, 0);
        rstn = 1'b1;
        sb.delete();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/waveword_seq.md
Name: waveword_seq

Overview:
- Upstream sequencer for the DA wave-word player.
- Reads a list of 32-bit wave words from a synchronous wave RAM, starting at a host-given base address.
- Presents each word to the player as {start[31:22], step[21:8], samples[7:0]} with a one-cycle req pulse, and advances to the next word on the player's ww_done.
- The list ends at a terminator word (samples==0). The list can be replayed a programmed number of times.

Parameters:
- ADDR_W, 10, wave RAM address width.
- LOOP_W, 8, width of the replay counter.

Ports:
- clk, input, 1, clock.
- rstn, input, 1, reset; asynchronous, active-low.
- start, input, 1, one-cycle pulse; begins a sequence. Ignored while busy.
- abort, input, 1, one-cycle pulse; stops the sequence.
- base_addr, input, ADDR_W, first word address. Sampled on start.
- loop_cnt, input, LOOP_W, number of extra passes (0 = play once). Sampled on start.
- rd_en, output, 1, wave RAM read strobe.
- rd_addr, output, ADDR_W, wave RAM address.
- rd_data, input, 32, RAM data, valid one cycle after rd_en.
- wave_word, output, 32, word to the player. Held stable from req until ww_done.
- req, output, 1, one-cycle pulse to the player.
- ww_done, input, 1, player finished the current word (one-cycle pulse).
- busy, output, 1, sequence in progress.
- seq_done, output, 1, one-cycle pulse when all passes have completed normally.
- addr_err, output, 1, sticky: last address reached with no terminator. Cleared on start.
- word_cnt, output, 16, words issued since start; saturates at 0xFFFF.

Behaviour:
- Reset values: all outputs 0. FSM in IDLE. rd_addr=0, wave_word=0.
- FSM states: IDLE, FETCH, WAIT_RD, ISSUE, RUN, DONE.
- IDLE:
  - start && !abort -> FETCH.
  - On this transition: latch base_addr into addr and loop_cnt into loops_left; clear word_cnt and addr_err.
- FETCH: rd_en=1, rd_addr=addr, for exactly one cycle. -> WAIT_RD.
- WAIT_RD: latch rd_data into wave_word at the end of the cycle. -> ISSUE.
- ISSUE: req=1 for one cycle; word_cnt increments. -> RUN.
- RUN: wait for ww_done. On ww_done:
  - wave_word[7:0]==0 (terminator) and loops_left!=0: decrement loops_left, addr<=base, -> FETCH.
  - wave_word[7:0]==0 and loops_left==0: -> DONE.
  - Not a terminator, addr != all-ones: addr<=addr+1, -> FETCH.
  - Not a terminator, addr == all-ones: set addr_err, -> IDLE. No seq_done; no wrap.
- DONE: seq_done=1 for one cycle. -> IDLE.
- The terminator word is itself issued to the player, which completes it immediately.
- busy=1 in every state except IDLE.
- req is never asserted for two consecutive cycles.
- Latency without the optional feature: start at cycle 0 -> rd_en at 1 -> req at 3. ww_done at T -> next rd_en at T+1 -> next req at T+3.
- abort, in any non-IDLE state:
  - -> IDLE next cycle; busy drops; no req; no seq_done.
  - Any in-flight rd_data is discarded.
  - A word already in progress in the player finishes there; its ww_done is ignored.
- abort in the same cycle as start: abort wins; stay IDLE.
- start while busy: ignored.
- ww_done outside RUN: ignored.
- rstn low at any time: immediate return to reset values, including mid-RUN.

Optional Feature:
- Macro: WAVEWORD_SEQ_PREFETCH_EN.
- Enabled:
  - During RUN, the next word is fetched into a 32-bit prefetch buffer with a valid flag.
  - Next address = base if the current word is a terminator and loops_left!=0; otherwise addr+1.
  - No prefetch when the current word is a terminator with loops_left==0, or when addr is all-ones.
  - On ww_done with a valid buffer: wave_word<=buffer and req at T+1; FETCH/WAIT_RD are skipped.
  - If the buffer is not yet valid: fall back to the normal path.
  - abort clears the buffer.
- Disabled: behaviour exactly as in Behaviour; no prefetch buffer logic.

Test Plan:
- Single word + terminator: base=0x010, loop_cnt=0, RAM[0x010]=0x4000_0105, RAM[0x011]=0x0000_0000, ww_done 5 cycles after each req -> two req pulses, word_cnt=2, seq_done once, busy low after.
- Looping: 3-word list (the third word is the terminator), loop_cnt=2 -> 9 req pulses; rd_addr returns to base twice; word_cnt=9; one seq_done.
- Abort in RUN: abort 2 cycles after the second req -> busy=0 next cycle; a later ww_done produces no req; no seq_done.
- Address end: base=0x3FE, no terminator in RAM, ADDR_W=10 -> words at 0x3FE and 0x3FF issued; addr_err=1; no seq_done. A following start clears addr_err.
- start+abort same cycle, and start while busy -> no state change, no rd_en.
- Prefetch timing (WAVEWORD_SEQ_PREFETCH_EN defined): ww_done at T -> req at T+1 with the new wave_word. Without the macro -> req at T+3.
